// File: rtl/framebuffer_swap_ctrl.sv
// framebuffer_swap_ctrl
//   Frame-control responder for the GPU controller. Owns double-buffer bank
//   selection, the post-swap clear sweep of the draw bank, and depth-tested
//   pixel writes from the fragment stage into a dual-port depth/colour memory.
//
// Ports
//   clk_in, rst_in         GPU clock; asynchronous active-low reset
//   clear_in, switch_in    one-cycle requests, honoured only while drawing
//   vblank_in              display vertical blank (already in clk_in domain)
//   ready_out              high while fragment pixels are accepted
//   valid_in, x_in, y_in,  fragment pixel; smaller z is nearer
//   z_in, rgb_in
//   rd_addr_out/rd_data_in depth/colour read port, data one cycle after addr
//   wr_en_out/wr_addr_out/ write port: clear sweep or depth-passing pixel
//   wr_data_out
//   draw_bank_out          bank being rendered
//   display_bank_out       bank being scanned out (always ~draw_bank_out)
//   drop_count_out         saturating count of discarded pixels
module framebuffer_swap_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear_in,
  input  logic              switch_in,
  input  logic              vblank_in,
  output logic              ready_out,
  input  logic              valid_in,
  input  logic [8:0]        x_in,
  input  logic [7:0]        y_in,
  input  logic [7:0]        z_in,
  input  logic [11:0]       rgb_in,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [19:0]       rd_data_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [19:0]       wr_data_out,
  output logic              draw_bank_out,
  output logic              display_bank_out,
  output logic [15:0]       drop_count_out
);

  localparam int unsigned       NPIX       = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [19:0]       CLEAR_WORD = 20'hFF000;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_DRAW,
    ST_PEND_SWAP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                armed_q;
  logic                clear_pend_q;
  logic                bank_q;
  logic [15:0]         drop_q;

  logic                s1_valid_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic [7:0]          s1_z_q;
  logic [11:0]         s1_rgb_q;

  logic                pw_en_q;
  logic [ADDR_W-1:0]   pw_addr_q;
  logic [19:0]         pw_data_q;

  logic                ready;
  logic                in_range;
  logic                accept;
  logic                drop;
  logic [ADDR_W-1:0]   pix_addr;
  logic                pipe_empty;
  logic                fwd;
  logic [7:0]          stored_z;
  logic                s1_wins;
  logic                sweep;
  logic                sweep_last;
  logic                unused_rd_rgb;

  assign unused_rd_rgb = ^rd_data_in[11:0];

  assign ready      = (state_q == ST_DRAW);
  assign in_range   = (32'(x_in) < 32'(WIDTH)) && (32'(y_in) < 32'(HEIGHT));
  assign accept     = valid_in && ready && in_range;
  assign drop       = valid_in && !accept;
  assign pix_addr   = ADDR_W'(32'(y_in) * 32'(WIDTH) + 32'(x_in));
  assign pipe_empty = !s1_valid_q && !pw_en_q;

  // The memory read for the stage-1 pixel was issued before the previous
  // pixel's write landed, so a same-address predecessor must be forwarded.
  assign fwd      = pw_en_q && (pw_addr_q == s1_addr_q);
  assign stored_z = fwd ? pw_data_q[19:12] : rd_data_in[19:12];
  assign s1_wins  = s1_valid_q && (s1_z_q < stored_z);

  // armed_q holds off the sweep for the first edge after reset so the
  // reset state (CLEAR) shows no write strobe while rst_in is low.
  assign sweep      = (state_q == ST_CLEAR) && armed_q;
  assign sweep_last = (clr_addr_q == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DRAW:      if (switch_in) state_d = ST_PEND_SWAP;
      ST_PEND_SWAP: if (vblank_in && pipe_empty)
                      state_d = clear_pend_q ? ST_CLEAR : ST_DRAW;
      ST_CLEAR:     if (sweep && sweep_last) state_d = ST_DRAW;
      default:      state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      armed_q      <= 1'b0;
      clear_pend_q <= 1'b0;
      bank_q       <= 1'b0;
      drop_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_z_q       <= '0;
      s1_rgb_q     <= '0;
      pw_en_q      <= 1'b0;
      pw_addr_q    <= '0;
      pw_data_q    <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;

      if (state_q == ST_DRAW && clear_in)
        clear_pend_q <= 1'b1;
      if (state_q == ST_PEND_SWAP && state_d != ST_PEND_SWAP) begin
        bank_q       <= ~bank_q;
        clear_pend_q <= 1'b0;
      end

      if (sweep)
        clr_addr_q <= sweep_last ? '0 : clr_addr_q + 1'b1;

      if (drop && drop_q != '1)
        drop_q <= drop_q + 16'd1;

      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= pix_addr;
        s1_z_q    <= z_in;
        s1_rgb_q  <= rgb_in;
      end

      pw_en_q <= s1_wins;
      if (s1_wins) begin
        pw_addr_q <= s1_addr_q;
        pw_data_q <= {s1_z_q, s1_rgb_q};
      end
    end
  end

  assign ready_out        = ready;
  assign rd_addr_out      = ready ? pix_addr : '0;
  assign wr_en_out        = sweep || pw_en_q;
  assign wr_addr_out      = sweep ? clr_addr_q : pw_addr_q;
  assign wr_data_out      = sweep ? CLEAR_WORD : pw_data_q;
  assign draw_bank_out    = bank_q;
  assign display_bank_out = ~bank_q;
  assign drop_count_out   = drop_q;

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Directed bench for framebuffer_swap_ctrl. DUT "a" is a 4x2 frame backed by
// a small two-bank memory; DUT "b" is 320 pixels wide to exercise the real
// line width and the x=320 range check.
module tb_framebuffer_swap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: WIDTH=4, HEIGHT=2
  logic        rst_a, clear_a, switch_a, vblank_a, valid_a;
  logic [8:0]  x_a;
  logic [7:0]  y_a, z_a;
  logic [11:0] rgb_a;
  logic        ready_a, wr_en_a, draw_a, disp_a;
  logic [2:0]  rd_addr_a, wr_addr_a;
  logic [19:0] rd_data_a, wr_data_a;
  logic [15:0] drop_a;
  logic [19:0] mem_a [0:15];

  // DUT b: WIDTH=320, HEIGHT=2
  logic        rst_b, valid_b;
  logic [8:0]  x_b;
  logic [7:0]  y_b, z_b;
  logic [11:0] rgb_b;
  logic        ready_b, wr_en_b, draw_b, disp_b;
  logic [9:0]  rd_addr_b, wr_addr_b;
  logic [19:0] rd_data_b, wr_data_b;
  logic [15:0] drop_b;

  int n_cmp = 0;
  int n_bad = 0;

  framebuffer_swap_ctrl #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3)) dut_a (
    .clk_in(clk), .rst_in(rst_a), .clear_in(clear_a), .switch_in(switch_a),
    .vblank_in(vblank_a), .ready_out(ready_a), .valid_in(valid_a),
    .x_in(x_a), .y_in(y_a), .z_in(z_a), .rgb_in(rgb_a),
    .rd_addr_out(rd_addr_a), .rd_data_in(rd_data_a), .wr_en_out(wr_en_a),
    .wr_addr_out(wr_addr_a), .wr_data_out(wr_data_a),
    .draw_bank_out(draw_a), .display_bank_out(disp_a), .drop_count_out(drop_a)
  );

  framebuffer_swap_ctrl #(.WIDTH(320), .HEIGHT(2), .ADDR_W(10)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .clear_in(1'b0), .switch_in(1'b0),
    .vblank_in(1'b0), .ready_out(ready_b), .valid_in(valid_b),
    .x_in(x_b), .y_in(y_b), .z_in(z_b), .rgb_in(rgb_b),
    .rd_addr_out(rd_addr_b), .rd_data_in(rd_data_b), .wr_en_out(wr_en_b),
    .wr_addr_out(wr_addr_b), .wr_data_out(wr_data_b),
    .draw_bank_out(draw_b), .display_bank_out(disp_b), .drop_count_out(drop_b)
  );

  assign rd_data_b = 20'hFF000;

  // Two-bank depth/colour memory with a one-cycle read for DUT a.
  always @(posedge clk) begin
    if (wr_en_a) mem_a[{draw_a, wr_addr_a}] <= wr_data_a;
    rd_data_a <= mem_a[{draw_a, rd_addr_a}];
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %0b want 0", ready_a); end
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got %0b want 0", wr_en_a); end
    n_cmp++; if (draw_a !== 1'b0) begin n_bad++; $display("FAIL rst_draw got %0b want 0", draw_a); end
    n_cmp++; if (disp_a !== 1'b1) begin n_bad++; $display("FAIL rst_disp got %0b want 1", disp_a); end
    n_cmp++; if (drop_a !== 16'd0) begin n_bad++; $display("FAIL rst_drop got %0h want 0", drop_a); end
    n_cmp++; if (rd_addr_a !== 3'd0 || wr_addr_a !== 3'd0 || wr_data_a !== 20'd0) begin
      n_bad++; $display("FAIL rst_addr_data got rd=%0h wa=%0h wd=%0h want 0/0/0", rd_addr_a, wr_addr_a, wr_data_a); end
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL rel_wr_en got %0b want 0", wr_en_a); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'(i) || wr_data_a !== 20'hFF000 || ready_a !== 1'b0) begin
        n_bad++; $display("FAIL init_sweep[%0d] got en=%0b a=%0d d=%0h rdy=%0b want 1/%0d/ff000/0", i, wr_en_a, wr_addr_a, wr_data_a, ready_a, i); end
    end
    @(negedge clk);
    n_cmp++; if (ready_a !== 1'b1 || wr_en_a !== 1'b0 || draw_a !== 1'b0) begin
      n_bad++; $display("FAIL init_done got rdy=%0b en=%0b bank=%0b want 1/0/0", ready_a, wr_en_a, draw_a); end
  endtask

  task automatic test_wide();
    for (int i = 0; i < 2000 && ready_b !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (ready_b !== 1'b1) begin n_bad++; $display("FAIL wide_ready_timeout got %0b want 1", ready_b); end
    @(negedge clk);
    valid_b = 1'b1; x_b = 9'd319; y_b = 8'd1; z_b = 8'h10; rgb_b = 12'h123;
    #1;
    n_cmp++; if (rd_addr_b !== 10'd639) begin n_bad++; $display("FAIL wide_rd_addr got %0d want 639", rd_addr_b); end
    @(negedge clk);
    x_b = 9'd320; y_b = 8'd0;
    @(negedge clk);
    valid_b = 1'b0;
    n_cmp++; if (wr_en_b !== 1'b1 || wr_addr_b !== 10'd639 || wr_data_b !== 20'h10123) begin
      n_bad++; $display("FAIL wide_write got en=%0b a=%0d d=%0h want 1/639/10123", wr_en_b, wr_addr_b, wr_data_b); end
    n_cmp++; if (drop_b !== 16'd1) begin n_bad++; $display("FAIL wide_drop got %0d want 1", drop_b); end
    @(negedge clk);
    n_cmp++; if (wr_en_b !== 1'b0 || drop_b !== 16'd1) begin
      n_bad++; $display("FAIL wide_x320_nowrite got en=%0b drop=%0d want 0/1", wr_en_b, drop_b); end
  endtask

  task automatic test_pixel();
    @(negedge clk);
    valid_a = 1'b1; x_a = 9'd3; y_a = 8'd1; z_a = 8'h10; rgb_a = 12'hABC;
    #1;
    n_cmp++; if (rd_addr_a !== 3'd7) begin n_bad++; $display("FAIL pix_rd_addr got %0d want 7", rd_addr_a); end
    @(negedge clk);
    valid_a = 1'b0;
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL pix_lat1 got en=%0b want 0", wr_en_a); end
    @(negedge clk);
    n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'd7 || wr_data_a !== 20'h10ABC) begin
      n_bad++; $display("FAIL pix_write got en=%0b a=%0d d=%0h want 1/7/10abc", wr_en_a, wr_addr_a, wr_data_a); end
    @(negedge clk);
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL pix_after got en=%0b want 0", wr_en_a); end
  endtask

  task automatic test_back_to_back();
    // z=0x40 then 0x50 at addr 5: second is blocked by the forwarded 0x40
    @(negedge clk);
    valid_a = 1'b1; x_a = 9'd1; y_a = 8'd1; z_a = 8'h40; rgb_a = 12'h111;
    @(negedge clk);
    z_a = 8'h50; rgb_a = 12'h222;
    @(negedge clk);
    valid_a = 1'b0;
    n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'd5 || wr_data_a !== 20'h40111) begin
      n_bad++; $display("FAIL b2b_first got en=%0b a=%0d d=%0h want 1/5/40111", wr_en_a, wr_addr_a, wr_data_a); end
    @(negedge clk);
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL b2b_fwd_block got en=%0b want 0", wr_en_a); end
    @(negedge clk);
    // z=0x40 then 0x30 at addr 6: both write
    valid_a = 1'b1; x_a = 9'd2; y_a = 8'd1; z_a = 8'h40; rgb_a = 12'h333;
    @(negedge clk);
    z_a = 8'h30; rgb_a = 12'h444;
    @(negedge clk);
    valid_a = 1'b0;
    n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'd6 || wr_data_a !== 20'h40333) begin
      n_bad++; $display("FAIL b2b_pair2_a got en=%0b a=%0d d=%0h want 1/6/40333", wr_en_a, wr_addr_a, wr_data_a); end
    @(negedge clk);
    n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'd6 || wr_data_a !== 20'h30444) begin
      n_bad++; $display("FAIL b2b_pair2_b got en=%0b a=%0d d=%0h want 1/6/30444", wr_en_a, wr_addr_a, wr_data_a); end
    @(negedge clk);
    // tie against stored 0x40 at addr 5 (read from memory) must not write
    valid_a = 1'b1; x_a = 9'd1; y_a = 8'd1; z_a = 8'h40; rgb_a = 12'h555;
    @(negedge clk);
    valid_a = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL tie_nowrite got en=%0b want 0", wr_en_a); end
    valid_a = 1'b1; z_a = 8'h3F; rgb_a = 12'h666;
    @(negedge clk);
    valid_a = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'd5 || wr_data_a !== 20'h3F666) begin
      n_bad++; $display("FAIL nearer_write got en=%0b a=%0d d=%0h want 1/5/3f666", wr_en_a, wr_addr_a, wr_data_a); end
    @(negedge clk);
  endtask

  task automatic test_drop();
    @(negedge clk);
    valid_a = 1'b1; x_a = 9'd4; y_a = 8'd0; z_a = 8'h01; rgb_a = 12'hFFF;
    @(negedge clk);
    n_cmp++; if (drop_a !== 16'd1) begin n_bad++; $display("FAIL drop_x got %0d want 1", drop_a); end
    x_a = 9'd0; y_a = 8'd2;
    @(negedge clk);
    valid_a = 1'b0;
    n_cmp++; if (drop_a !== 16'd2) begin n_bad++; $display("FAIL drop_y got %0d want 2", drop_a); end
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL drop_nowrite1 got en=%0b want 0", wr_en_a); end
    @(negedge clk);
    n_cmp++; if (wr_en_a !== 1'b0) begin n_bad++; $display("FAIL drop_nowrite2 got en=%0b want 0", wr_en_a); end
  endtask

  task automatic test_swap_clear();
    @(negedge clk);
    switch_a = 1'b1; clear_a = 1'b1;
    @(negedge clk);
    switch_a = 1'b0; clear_a = 1'b0;
    n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL swap_ready_drop got %0b want 0", ready_a); end
    valid_a = 1'b1; x_a = 9'd3; y_a = 8'd1; z_a = 8'h01;
    @(negedge clk);
    valid_a = 1'b0;
    n_cmp++; if (drop_a !== 16'd3) begin n_bad++; $display("FAIL notready_drop got %0d want 3", drop_a); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (ready_a !== 1'b0 || draw_a !== 1'b0) begin
        n_bad++; $display("FAIL pend_wait[%0d] got rdy=%0b bank=%0b want 0/0", i, ready_a, draw_a); end
    end
    vblank_a = 1'b1;
    @(negedge clk);
    vblank_a = 1'b0;
    n_cmp++; if (draw_a !== 1'b1 || disp_a !== 1'b0) begin
      n_bad++; $display("FAIL swap_bank got draw=%0b disp=%0b want 1/0", draw_a, disp_a); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'(i) || wr_data_a !== 20'hFF000 || ready_a !== 1'b0) begin
        n_bad++; $display("FAIL swap_sweep[%0d] got en=%0b a=%0d d=%0h rdy=%0b want 1/%0d/ff000/0", i, wr_en_a, wr_addr_a, wr_data_a, ready_a, i); end
      @(negedge clk);
    end
    n_cmp++; if (ready_a !== 1'b1 || wr_en_a !== 1'b0) begin
      n_bad++; $display("FAIL swap_done got rdy=%0b en=%0b want 1/0", ready_a, wr_en_a); end
  endtask

  task automatic test_swap_drain();
    @(negedge clk);
    valid_a = 1'b1; x_a = 9'd0; y_a = 8'd0; z_a = 8'h20; rgb_a = 12'h777;
    switch_a = 1'b1; vblank_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; switch_a = 1'b0; clear_a = 1'b1;
    n_cmp++; if (ready_a !== 1'b0 || draw_a !== 1'b1) begin
      n_bad++; $display("FAIL drain_pend got rdy=%0b bank=%0b want 0/1", ready_a, draw_a); end
    @(negedge clk);
    clear_a = 1'b0;
    n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'd0 || wr_data_a !== 20'h20777 || draw_a !== 1'b1) begin
      n_bad++; $display("FAIL drain_write got en=%0b a=%0d d=%0h bank=%0b want 1/0/20777/1", wr_en_a, wr_addr_a, wr_data_a, draw_a); end
    @(negedge clk);
    n_cmp++; if (draw_a !== 1'b1 || ready_a !== 1'b0) begin
      n_bad++; $display("FAIL drain_hold got bank=%0b rdy=%0b want 1/0", draw_a, ready_a); end
    @(negedge clk);
    vblank_a = 1'b0;
    n_cmp++; if (draw_a !== 1'b0 || ready_a !== 1'b1 || wr_en_a !== 1'b0) begin
      n_bad++; $display("FAIL noclear_swap got bank=%0b rdy=%0b en=%0b want 0/1/0", draw_a, ready_a, wr_en_a); end
  endtask

  task automatic test_early_clear_and_reset();
    @(negedge clk);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    repeat (2) @(negedge clk);
    switch_a = 1'b1; vblank_a = 1'b1;
    @(negedge clk);
    switch_a = 1'b0;
    n_cmp++; if (ready_a !== 1'b0 || draw_a !== 1'b0) begin
      n_bad++; $display("FAIL early_pend got rdy=%0b bank=%0b want 0/0", ready_a, draw_a); end
    @(negedge clk);
    vblank_a = 1'b0;
    n_cmp++; if (draw_a !== 1'b1 || wr_en_a !== 1'b1 || wr_addr_a !== 3'd0) begin
      n_bad++; $display("FAIL early_clear_start got bank=%0b en=%0b a=%0d want 1/1/0", draw_a, wr_en_a, wr_addr_a); end
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_addr_a !== 3'd2) begin n_bad++; $display("FAIL mid_sweep_addr got %0d want 2", wr_addr_a); end
    #2;
    rst_a = 1'b0;
    #1;
    n_cmp++; if (ready_a !== 1'b0 || wr_en_a !== 1'b0 || draw_a !== 1'b0 || disp_a !== 1'b1) begin
      n_bad++; $display("FAIL async_rst got rdy=%0b en=%0b draw=%0b disp=%0b want 0/0/0/1", ready_a, wr_en_a, draw_a, disp_a); end
    n_cmp++; if (drop_a !== 16'd0 || wr_addr_a !== 3'd0) begin
      n_bad++; $display("FAIL async_rst_cnt got drop=%0d a=%0d want 0/0", drop_a, wr_addr_a); end
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (wr_en_a !== 1'b1 || wr_addr_a !== 3'(i) || wr_data_a !== 20'hFF000) begin
        n_bad++; $display("FAIL restart_sweep[%0d] got en=%0b a=%0d d=%0h want 1/%0d/ff000", i, wr_en_a, wr_addr_a, wr_data_a, i); end
    end
    @(negedge clk);
    n_cmp++; if (ready_a !== 1'b1 || draw_a !== 1'b0) begin
      n_bad++; $display("FAIL restart_done got rdy=%0b bank=%0b want 1/0", ready_a, draw_a); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    valid_a = 1'b1; x_a = 9'd4; y_a = 8'd0;
    repeat (65534) @(negedge clk);
    n_cmp++; if (drop_a !== 16'hFFFE) begin n_bad++; $display("FAIL sat_fffe got %0h want fffe", drop_a); end
    @(negedge clk);
    n_cmp++; if (drop_a !== 16'hFFFF) begin n_bad++; $display("FAIL sat_ffff got %0h want ffff", drop_a); end
    repeat (3) @(negedge clk);
    valid_a = 1'b0;
    n_cmp++; if (drop_a !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %0h want ffff", drop_a); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_a[i] = 20'h0;
    rst_a = 1'b0; clear_a = 1'b0; switch_a = 1'b0; vblank_a = 1'b0; valid_a = 1'b0;
    x_a = '0; y_a = '0; z_a = '0; rgb_a = '0;
    rst_b = 1'b0; valid_b = 1'b0; x_b = '0; y_b = '0; z_b = '0; rgb_b = '0;

    test_reset();
    test_wide();
    test_pixel();
    test_back_to_back();
    test_drop();
    test_swap_clear();
    test_swap_drain();
    test_early_clear_and_reset();
    test_saturate();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_swap_ctrl.md
Name: framebuffer_swap_ctrl

Overview:
- Responder for the frame-control handshake driven by the GPU controller: accepts `switch_in`/`clear_in` pulses and reports `ready_out`; the controller waits for `ready_out` before releasing vertex fetch.
- Owns double-buffer bank selection, the post-swap clear sweep, and depth-tested pixel writes from the fragment stage into a dual-port depth/colour memory.
- Sits between `fragment_shader` and the framebuffer memories; the display scanout reads the bank given by `display_bank_out`.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- ADDR_W, 17, memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk_in  in  1  GPU clock.
- rst_in  in  1  asynchronous, active-low reset.
- clear_in  in  1  single-cycle pulse: clear the draw bank at the next swap.
- switch_in  in  1  single-cycle pulse: request a bank swap.
- vblank_in  in  1  display vertical blank, already synchronous to clk_in.
- ready_out  out  1  high when pixels are accepted.
- valid_in  in  1  pixel valid.
- x_in  in  9  pixel x.
- y_in  in  8  pixel y.
- z_in  in  8  pixel depth; smaller is nearer.
- rgb_in  in  12  pixel colour.
- rd_addr_out  out  ADDR_W  depth/colour read address in the draw bank.
- rd_data_in  in  20  {z[19:12], rgb[11:0]}; valid 1 cycle after rd_addr_out.
- wr_en_out  out  1  write strobe.
- wr_addr_out  out  ADDR_W  write address.
- wr_data_out  out  20  {z, rgb}.
- draw_bank_out  out  1  bank being rendered.
- display_bank_out  out  1  bank being scanned out; always ~draw_bank_out.
- drop_count_out  out  16  pixels discarded (not ready or out of range); saturates at 0xFFFF.

Behaviour:
- Reset (`rst_in` low, asynchronous) sets every output to 0 except `display_bank_out`=1: `ready_out`=0, `wr_en_out`=0, `draw_bank_out`=0, `drop_count_out`=0. State goes to CLEAR with clear address 0; pending flags are cleared. When reset is released, the first action is a full clear of bank 0.
- States:
  - DRAW: `ready_out`=1.
  - PEND_SWAP: `ready_out`=0; waiting for vblank.
  - CLEAR: `ready_out`=0; sweeping the draw bank.
- DRAW -> PEND_SWAP on `switch_in`. `clear_in` in the same or any earlier DRAW cycle sets `clear_pending`.
- PEND_SWAP -> on the first cycle with `vblank_in`=1 and the depth pipeline empty: toggle `draw_bank_out`; then go to CLEAR if `clear_pending` (and clear it), else to DRAW.
- CLEAR: one write per cycle, `wr_addr_out`=0..WIDTH*HEIGHT-1, `wr_data_out`=20'hFF000. After the last address, go to DRAW next cycle; `ready_out` rises that cycle. Sweep length is exactly WIDTH*HEIGHT cycles.
- `switch_in` or `clear_in` outside DRAW is ignored.
- Pixel address = y_in*WIDTH + x_in, computed combinationally in stage 0.
- A pixel is dropped and `drop_count_out` increments when any of these holds:
  - `ready_out`=0;
  - x_in >= WIDTH;
  - y_in >= HEIGHT.
- Depth pipeline, 2 stages:
  - Stage 0 (accept cycle): `rd_addr_out` = address; pixel is registered into stage 1.
  - Stage 1: compare z against the stored z (`rd_data_in[19:12]`). If z_in < stored z, assert `wr_en_out` with {z_in, rgb_in}. Ties do not write.
  - Write latency is 2 cycles from accept.
- Forwarding: if the stage-1 pixel writes and the next pixel (now in stage 1) has the same address, the compare uses the forwarded written z instead of `rd_data_in`.
- Throughput: one pixel per cycle in DRAW; the pipeline drains during PEND_SWAP before the toggle.
- In CLEAR, `rd_addr_out` is don't-care and no depth writes occur.

Test Plan:
- Reset release, WIDTH=4, HEIGHT=2 -> `ready_out`=0 for 8 cycles; writes to addresses 0..7 with 20'hFF000; then `ready_out`=1 and `draw_bank_out`=0.
- Pixel (x=3, y=1, z=0x10, rgb=0xABC) in DRAW -> `rd_addr_out`=7 on the accept cycle; `wr_en_out`=1 at addr 7 with data 0x10ABC two cycles after accept.
- Back-to-back pixels at addr 5 with z=0x40 then z=0x50 -> only the first writes (forwarded z=0x40 blocks the second). With z=0x40 then z=0x30, both write.
- `switch_in` and `clear_in` pulsed together while `vblank_in`=0 for 10 cycles, then 1 -> `ready_out`=0 from the next cycle; bank toggles to 1 on the first vblank cycle; full clear sweep runs; `ready_out`=1 after it.
- `switch_in` without `clear_in` -> bank toggles at vblank; `ready_out` returns 1 the following cycle with no clear writes.
- Pixels with x=320 (default params), or pixels while `ready_out`=0 -> no write; `drop_count_out` increments per pixel and saturates at 0xFFFF.
- Assert `rst_in` low mid-sweep -> outputs return to reset values immediately (asynchronously); the sweep restarts at address 0 after release.
